// File: rtl/alarm_clock_core.sv
// alarm_clock_core: HH:MM:SS timekeeper with alarm/snooze FSM, debounced buttons and registered 7-segment/LED drivers
module alarm_clock_core #(
    parameter int CLK_HZ          = 50000000,
    parameter int NUM_DIGITS      = 6,
    parameter bit SEG_ACTIVE_LOW  = 1,
    parameter int LED_W           = 10,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SNOOZE_MIN      = 5,
    parameter int RING_TIMEOUT_S  = 60
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    hour_changer_export,
    input  logic                    min_changer_export,
    input  logic                    interrupbutton_export,
    input  logic                    snooze_export,
    input  logic                    mode_24h,
    input  logic                    time_wr,
    input  logic                    alarm_wr,
    input  logic [4:0]              wr_hh,
    input  logic [5:0]              wr_mm,
    input  logic [5:0]              wr_ss,
    input  logic                    wr_en_alarm,
    output logic [NUM_DIGITS*8-1:0] segments_export,
    output logic [LED_W-1:0]        leds_export,
    output logic                    alarm_ringing,
    output logic                    sec_pulse
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam int OFF = 6 - NUM_DIGITS;
    localparam logic [7:0] SEG_ZERO = SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;
    localparam logic [NUM_DIGITS*8-1:0] SEG_RST = {NUM_DIGITS{SEG_ZERO}};

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    logic [PW-1:0]           r_pre;
    logic                    w_tick;
    logic [4:0]              r_hh, r_al_hh, w_hh_n, w_h;
    logic [5:0]              r_mm, r_ss, r_al_mm, w_mm_n, w_ss_n, w_hh_sum;
    logic [6:0]              w_mm_sum;
    logic                    r_al_en, w_c1, w_c2, w_match;
    logic [3:0]              w_raw, w_rise;
    state_t                  r_state, w_state_n;
    logic [RW-1:0]           r_ring;
    logic [SW-1:0]           r_snz;
    logic                    r_blink, r_sec;
    logic [LED_W-1:0]        r_leds;
    logic [3:0]              w_dig [6];
    logic [5:0]              w_dp;
    logic [NUM_DIGITS*8-1:0] w_seg, r_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign w_tick = r_pre == PW'(CLK_HZ - 1);
    assign w_raw = {snooze_export, interrupbutton_export, min_changer_export, hour_changer_export};

    for (genvar g = 0; g < 4; g++) begin : g_db
        logic          r_s1, r_s2, r_db;
        logic [CW-1:0] r_cnt;
        // synchronise the raw button, then accept a new level only after it differs for DEBOUNCE_CYCLES samples
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                if (r_s2 == r_db) r_cnt <= '0;
                else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else r_cnt <= r_cnt + 1'b1;
            end
        end
        assign w_rise[g] = r_s2 && !r_db && r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    end

    // next time value: tick carry chain plus hour/minute button increments in the same cycle
    always_comb begin
        w_c1     = w_tick && r_ss == 6'd59;
        w_c2     = w_c1 && r_mm == 6'd59;
        w_mm_sum = 7'(r_mm) + 7'(w_c1) + 7'(w_rise[1]);
        w_hh_sum = 6'(r_hh) + 6'(w_c2) + 6'(w_rise[0]);
        w_mm_n   = w_mm_sum >= 7'd60 ? 6'(w_mm_sum - 7'd60) : w_mm_sum[5:0];
        w_hh_n   = w_hh_sum >= 6'd24 ? 5'(w_hh_sum - 6'd24) : w_hh_sum[4:0];
        w_ss_n   = w_rise[1] ? 6'd0 : w_tick ? (r_ss == 6'd59 ? 6'd0 : r_ss + 6'd1) : r_ss;
        w_match  = w_tick && !time_wr && r_al_en && w_hh_n == r_al_hh && w_mm_n == r_al_mm && w_ss_n == 6'd0;
    end

    // prescaler and time counters; a CPU time write overrides the tick and the buttons
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pre <= '0;
            r_hh  <= '0;
            r_mm  <= '0;
            r_ss  <= '0;
        end else if (time_wr) begin
            r_pre <= '0;
            r_hh  <= wr_hh;
            r_mm  <= wr_mm;
            r_ss  <= wr_ss;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            r_hh  <= w_hh_n;
            r_mm  <= w_mm_n;
            r_ss  <= w_ss_n;
        end
    end

    // alarm time and enable written by the CPU
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_al_hh <= '0;
            r_al_mm <= '0;
            r_al_en <= 1'b0;
        end else if (alarm_wr) begin
            r_al_hh <= wr_hh;
            r_al_mm <= wr_mm;
            r_al_en <= wr_en_alarm;
        end
    end

    // alarm next state: disabling write wins, then ack over snooze, then timeouts
    always_comb begin
        w_state_n = r_state;
        if (alarm_wr && !wr_en_alarm) w_state_n = IDLE;
        else if (r_state == IDLE) w_state_n = w_match ? RINGING : IDLE;
        else if (r_state == RINGING)
            w_state_n = w_rise[2] ? IDLE : w_rise[3] ? SNOOZE :
                        (w_tick && r_ring == RW'(RING_TIMEOUT_S - 1)) ? IDLE : RINGING;
        else if (r_state == SNOOZE)
            w_state_n = w_rise[2] ? IDLE : (w_tick && r_snz == SW'(1)) ? RINGING : SNOOZE;
    end

    // alarm state register with ring timeout, snooze countdown and blink phase
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
            r_ring  <= '0;
            r_snz   <= '0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_state_n == RINGING && r_state != RINGING) begin
                r_ring  <= '0;
                r_blink <= 1'b1;
            end else if (r_state == RINGING && w_tick) begin
                r_ring  <= r_ring + 1'b1;
                r_blink <= !r_blink;
            end
            if (w_state_n == SNOOZE && r_state == RINGING) r_snz <= SW'(SNOOZE_MIN * 60);
            else if (r_state == SNOOZE && w_tick) r_snz <= r_snz - 1'b1;
        end
    end

    // display digits; the alarm DP sits on mm-ones in both layouts, PM takes the rightmost digit in 12-hour mode
    always_comb begin
        w_h      = mode_24h ? r_hh : r_hh == 5'd0 ? 5'd12 : r_hh > 5'd12 ? r_hh - 5'd12 : r_hh;
        w_dig[0] = 4'(r_ss % 6'd10);
        w_dig[1] = 4'(r_ss / 6'd10);
        w_dig[2] = 4'(r_mm % 6'd10);
        w_dig[3] = 4'(r_mm / 6'd10);
        w_dig[4] = 4'(w_h % 5'd10);
        w_dig[5] = 4'(w_h / 5'd10);
        w_dp     = '0;
        w_dp[2]  = r_al_en;
        if (!mode_24h) w_dp[OFF] = r_hh >= 5'd12;
        w_seg = '0;
        for (int i = 0; i < NUM_DIGITS; i++) w_seg[8*i +: 8] = {w_dp[i+OFF], seg7(w_dig[i+OFF])};
    end

    // registered board outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sec  <= 1'b0;
            r_leds <= '0;
            r_seg  <= SEG_RST;
        end else begin
            r_sec  <= w_tick;
            r_leds <= r_state == RINGING ? {LED_W{r_blink}} : r_state == SNOOZE ? LED_W'(1) : '0;
            r_seg  <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
        end
    end

    assign segments_export = r_seg;
    assign leds_export     = r_leds;
    assign alarm_ringing   = r_state == RINGING;
    assign sec_pulse       = r_sec;
endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed plus randomized stimulus checked every cycle against a seconds-of-day reference model
module tb_alarm_clock_core;
    localparam int CLK = 10;
    localparam int DB = 4;
    localparam int RT = 60;
    localparam int SN = 300;
    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  btn = '0;
    logic        mode_24h = 1'b1;
    logic        time_wr = 1'b0, alarm_wr = 1'b0, wr_en_alarm = 1'b0;
    logic [4:0]  wr_hh = '0;
    logic [5:0]  wr_mm = '0, wr_ss = '0;
    logic [47:0] segments;
    logic [9:0]  leds;
    logic        alarm_ringing, sec_pulse;

    int n_checks = 0, n_err = 0;
    int t_sec, pre, ah, am, st, ring_left, snz_left;
    bit aen;
    bit [3:0] dly1, dly2, db;
    int run [4];
    logic [47:0] e_seg;
    logic [9:0]  e_led;
    logic        e_sec;

    alarm_clock_core #(
        .CLK_HZ(CLK), .NUM_DIGITS(6), .SEG_ACTIVE_LOW(1'b1), .LED_W(10),
        .DEBOUNCE_CYCLES(DB), .SNOOZE_MIN(5), .RING_TIMEOUT_S(RT)
    ) dut (
        .clk_clk(clk), .reset_reset_n(reset_n),
        .hour_changer_export(btn[0]), .min_changer_export(btn[1]),
        .interrupbutton_export(btn[2]), .snooze_export(btn[3]),
        .mode_24h(mode_24h), .time_wr(time_wr), .alarm_wr(alarm_wr),
        .wr_hh(wr_hh), .wr_mm(wr_mm), .wr_ss(wr_ss), .wr_en_alarm(wr_en_alarm),
        .segments_export(segments), .leds_export(leds),
        .alarm_ringing(alarm_ringing), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [47:0] disp(input int t, input bit al_en, input bit m24);
        int h = t / 3600, m = (t / 60) % 60, s = t % 60;
        int hd = m24 ? h : (h % 12 == 0 ? 12 : h % 12);
        int d [6] = '{s % 10, s / 10, m % 10, m / 10, hd % 10, hd / 10};
        logic [7:0] b;
        logic [47:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            b = {1'b0, SEG_TBL[d[i]]};
            if (i == 0 && !m24 && h >= 12) b[7] = 1'b1;
            if (i == 2 && al_en) b[7] = 1'b1;
            r[8*i +: 8] = ~b;
        end
        return r;
    endfunction

    task automatic model_reset();
        t_sec = 0; pre = 0; ah = 0; am = 0; aen = 0; st = 0; ring_left = 0; snz_left = 0;
        dly1 = '0; dly2 = '0; db = '0;
        for (int b = 0; b < 4; b++) run[b] = 0;
    endtask

    task automatic model_step();
        bit tick, match, oaen;
        bit [3:0] fire = '0;
        int h, m, s, oah, oam;
        tick = pre == CLK - 1;
        e_sec = tick;
        e_seg = disp(t_sec, aen, mode_24h);
        e_led = st == 1 ? (((RT - ring_left) % 2 == 0) ? 10'h3FF : 10'h000) : st == 2 ? 10'h001 : 10'h000;
        for (int b = 0; b < 4; b++) begin
            if (dly2[b] != db[b]) begin
                run[b]++;
                if (run[b] == DB) begin
                    db[b] = dly2[b];
                    run[b] = 0;
                    fire[b] = db[b];
                end
            end else run[b] = 0;
        end
        dly2 = dly1;
        dly1 = btn;
        pre = (time_wr || tick) ? 0 : pre + 1;
        oah = ah; oam = am; oaen = aen;
        if (alarm_wr) begin ah = int'(wr_hh); am = int'(wr_mm); aen = wr_en_alarm; end
        if (time_wr) t_sec = int'(wr_hh) * 3600 + int'(wr_mm) * 60 + int'(wr_ss);
        else begin
            if (tick) t_sec = (t_sec + 1) % 86400;
            h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
            if (fire[0]) h = (h + 1) % 24;
            if (fire[1]) begin m = (m + 1) % 60; s = 0; end
            t_sec = h * 3600 + m * 60 + s;
        end
        match = tick && !time_wr && oaen && t_sec == oah * 3600 + oam * 60;
        if (alarm_wr && !wr_en_alarm) st = 0;
        else if (st == 0) begin
            if (match) begin st = 1; ring_left = RT; end
        end else if (st == 1) begin
            if (fire[2]) st = 0;
            else if (fire[3]) begin st = 2; snz_left = SN; end
            else if (tick) begin ring_left--; if (ring_left == 0) st = 0; end
        end else begin
            if (fire[2]) st = 0;
            else if (tick) begin snz_left--; if (snz_left == 0) begin st = 1; ring_left = RT; end end
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check("seg", segments, e_seg);
            check("led", leds, e_led);
            check("sec", sec_pulse, e_sec);
            check("ring", alarm_ringing, st == 1);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        wr_hh = 5'(h); wr_mm = 6'(m); wr_ss = 6'(s);
        time_wr = 1'b1; cyc(); time_wr = 1'b0;
    endtask

    task automatic set_alarm(input int h, input int m, input bit en);
        wr_hh = 5'(h); wr_mm = 6'(m); wr_en_alarm = en;
        alarm_wr = 1'b1; cyc(); alarm_wr = 1'b0;
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1; cyc(hold); btn[b] = 1'b0; cyc(8);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg"}, segments, {6{8'hC0}});
        check({tag, "_led"}, leds, 10'h000);
        check({tag, "_sec"}, sec_pulse, 1'b0);
        check({tag, "_ring"}, alarm_ringing, 1'b0);
    endtask

    initial begin
        int k, h, m;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_values("rst");
        @(negedge clk) reset_n = 1'b1;
        cyc(12);
        set_time(23, 59, 59);
        cyc(12);
        set_alarm(7, 30, 1'b1);
        set_time(7, 29, 59);
        cyc(12);
        check("ring_start", alarm_ringing, 1'b1);
        cyc(RT * CLK + 10);
        set_time(7, 29, 59);
        cyc(12);
        press(3, 8);
        check("snooze_led", leds, 10'h001);
        cyc(SN * CLK + 10);
        check("resnooze_ring", alarm_ringing, 1'b1);
        press(3, 8);
        cyc(50);
        press(2, 8);
        check("ack_idle", alarm_ringing, 1'b0);
        set_time(23, 10, 42);
        press(0, 6);
        press(0, 3);
        set_time(10, 59, 30);
        press(1, 6);
        mode_24h = 1'b0;
        set_time(13, 5, 0);
        cyc(3);
        check("pm_disp", segments, disp(13 * 3600 + 5 * 60, 1'b1, 1'b0));
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                1: begin
                    h = $urandom_range(0, 23); m = $urandom_range(0, 59);
                    set_alarm(h, m, $urandom_range(0, 3) != 0);
                    k = (h * 3600 + m * 60 - $urandom_range(1, 3) + 86400) % 86400;
                    set_time(k / 3600, (k / 60) % 60, k % 60);
                    cyc(40);
                end
                2: press($urandom_range(0, 3), $urandom_range(2, 8));
                3: begin mode_24h = !mode_24h; cyc(2); end
                4: cyc($urandom_range(5, 60));
                default: set_alarm($urandom_range(0, 23), $urandom_range(0, 59), 1'b0);
            endcase
        end
        mode_24h = 1'b1;
        set_alarm(12, 0, 1'b1);
        set_time(11, 59, 58);
        cyc(25);
        check("pre_rst_ring", alarm_ringing, 1'b1);
        #3 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_values("held_rst");
        @(negedge clk) reset_n = 1'b1;
        cyc(15);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
